// File: rtl/pic_pkg.sv
// Shared constants for the PIC request path: default sizes, ID width
// derivation and the trigger-mode encodings also used by the ICW1 decoder.
package pic_pkg;

    localparam int NUM_IRQ_DEF     = 8;
    localparam int SYNC_STAGES_DEF = 2;

    // Trigger mode of one channel, as carried on ltim[i].
    typedef enum logic {
        LTIM_EDGE  = 1'b0,
        LTIM_LEVEL = 1'b1
    } ltim_mode_e;

    // Width needed to name any of n channels (never narrower than 1 bit).
    function automatic int calc_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irr_channel.sv
// One request channel: synchroniser, edge detector, trigger-mode history
// and the irr bit itself.
module irr_channel
    import pic_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ir_in,
    input  logic ltim,
    input  logic clr,
    output logic irr
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    // vld_q[k] marks that sync_q[k] (or prev for k = SYNC_STAGES) holds a
    // real sample taken after reset rather than the reset zero. Without it a
    // line held high through reset would look like a fresh rising edge once
    // the chain refills.
    logic [SYNC_STAGES:0]   vld_q, vld_d;
    logic                   prev_q, prev_d;
    logic                   ltim_hist_q, ltim_hist_d;
    logic                   irr_q, irr_d;
    logic                   s, rise, mode_chg;

    // Next-state: shift the synchroniser, detect edges, apply mode rules.
    always_comb begin
        s           = sync_q[SYNC_STAGES-1];
        rise        = s & ~prev_q & vld_q[SYNC_STAGES];
        mode_chg    = (ltim != ltim_hist_q);
        sync_d      = {sync_q[SYNC_STAGES-2:0], ir_in};
        vld_d       = {vld_q[SYNC_STAGES-1:0], 1'b1};
        prev_d      = s;
        ltim_hist_d = ltim;
        irr_d       = irr_q;
        if (mode_chg) begin
            // Reload on a mode switch; a line already high gives no edge.
            irr_d = (ltim == LTIM_LEVEL) ? s : 1'b0;
        end else if (ltim == LTIM_LEVEL) begin
            irr_d = s;
        end else if (rise) begin
            irr_d = 1'b1;       // a new edge beats a same-cycle ack
        end else if (clr) begin
            irr_d = 1'b0;
        end
    end

    // State registers; the mode history tracks ltim even during reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q      <= '0;
            vld_q       <= '0;
            prev_q      <= 1'b0;
            ltim_hist_q <= ltim;
            irr_q       <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            vld_q       <= vld_d;
            prev_q      <= prev_d;
            ltim_hist_q <= ltim_hist_d;
            irr_q       <= irr_d;
        end
    end

    assign irr = irr_q;

endmodule

// File: rtl/irr_multi_mode.sv
// Interrupt request register: per-channel capture, acknowledge decode and a
// registered fixed-priority (channel 0 highest) pending/ID pair.
module irr_multi_mode
    import pic_pkg::*;
#(
    parameter  int NUM_IRQ     = NUM_IRQ_DEF,
    parameter  int SYNC_STAGES = SYNC_STAGES_DEF,
    localparam int ID_W        = calc_id_w(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_IRQ-1:0] ir_in,
    input  logic [NUM_IRQ-1:0] ltim,
    input  logic [NUM_IRQ-1:0] imr,
    input  logic               ack_valid,
    input  logic [ID_W-1:0]    ack_id,
    output logic [NUM_IRQ-1:0] irr,
    output logic               irq_pending,
    output logic [ID_W-1:0]    highest_id
);

    logic [NUM_IRQ-1:0] clr;
    logic [NUM_IRQ-1:0] pend;
    logic               pending_q, pending_d;
    logic [ID_W-1:0]    id_q, id_d;

    // Ack decode: IDs at or above NUM_IRQ match no channel and are dropped.
    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_ch
        assign clr[g] = ack_valid && (ack_id == ID_W'(g));

        irr_channel #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .ir_in   (ir_in[g]),
            .ltim    (ltim[g]),
            .clr     (clr[g]),
            .irr     (irr[g])
        );
    end

    // Priority encode of unmasked requests; lowest index wins.
    always_comb begin
        pend      = irr & ~imr;
        pending_d = |pend;
        id_d      = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend[i]) id_d = ID_W'(i);
        end
    end

    // Register the encoder result so outputs carry no input-to-output path.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pending_q <= 1'b0;
            id_q      <= '0;
        end else begin
            pending_q <= pending_d;
            id_q      <= id_d;
        end
    end

    assign irq_pending = pending_q;
    assign highest_id  = id_q;

endmodule

// File: tb/tb_irr_multi_mode.sv
// Bench for irr_multi_mode: an 8-channel and a 6-channel instance share
// stimulus; a sample-history model predicts irr and the pending/ID pair.
module tb_irr_multi_mode;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] ir_in, ltim, imr;
    logic       ack_valid;
    logic [2:0] ack_id;
    logic [7:0] irr8;
    logic       pend8_o;
    logic [2:0] id8_o;
    logic [5:0] irr6;
    logic       pend6_o;
    logic [2:0] id6_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    irr_multi_mode #(.NUM_IRQ(8), .SYNC_STAGES(S)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .ltim(ltim), .imr(imr),
        .ack_valid(ack_valid), .ack_id(ack_id), .irr(irr8),
        .irq_pending(pend8_o), .highest_id(id8_o)
    );

    irr_multi_mode #(.NUM_IRQ(6), .SYNC_STAGES(S)) u_dut6 (
        .clk(clk), .reset_n(reset_n), .ir_in(ir_in[5:0]), .ltim(ltim[5:0]),
        .imr(imr[5:0]), .ack_valid(ack_valid), .ack_id(ack_id), .irr(irr6),
        .irq_pending(pend6_o), .highest_id(id6_o)
    );

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [2:0] low_idx(input logic [7:0] v);
        logic [2:0] r;
        r = '0;
        for (int i = 7; i >= 0; i--) if (v[i]) r = 3'(i);
        return r;
    endfunction

    // Model: smp[k] is ir_in as sampled k+1 edges ago (zero before reset
    // release); the synchronised line is the sample S edges old.
    logic [7:0] smp [0:S];
    int         n_live;
    logic [7:0] m_irr, m_ltim_prev;
    logic       m_pend8, m_pend6;
    logic [2:0] m_id8, m_id6;
    logic       model_ok = 1'b0;

    always @(posedge clk) begin
        logic [7:0] s, p, rise, nxt, pv8, pv6;
        if (!reset_n) begin
            for (int k = 0; k <= S; k++) smp[k] = '0;
            n_live      = 0;
            m_irr       = '0;
            m_pend8     = 1'b0;
            m_pend6     = 1'b0;
            m_id8       = '0;
            m_id6       = '0;
            m_ltim_prev = ltim;
            model_ok    = 1'b1;
        end else begin
            s    = smp[S-1];
            p    = smp[S];
            rise = (n_live >= S + 1) ? (s & ~p) : 8'h00;
            pv8  = m_irr & ~imr;
            pv6  = m_irr & ~imr & 8'h3F;
            m_pend8 = |pv8;
            m_id8   = low_idx(pv8);
            m_pend6 = |pv6;
            m_id6   = low_idx(pv6);
            nxt = m_irr;
            for (int i = 0; i < 8; i++) begin
                if (ltim[i] != m_ltim_prev[i]) nxt[i] = ltim[i] ? s[i] : 1'b0;
                else if (ltim[i])              nxt[i] = s[i];
                else if (rise[i])              nxt[i] = 1'b1;
                else if (ack_valid && ack_id == 3'(i)) nxt[i] = 1'b0;
            end
            m_irr       = nxt;
            m_ltim_prev = ltim;
            for (int k = S; k > 0; k--) smp[k] = smp[k-1];
            smp[0] = ir_in;
            if (n_live < 100) n_live++;
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (model_ok) begin
            cmp("irr8", irr8, m_irr);
            cmp("pend8", pend8_o, m_pend8);
            cmp("id8", id8_o, m_id8);
            cmp("irr6", irr6, m_irr[5:0]);
            cmp("pend6", pend6_o, m_pend6);
            cmp("id6", id6_o, m_id6);
        end
    end

    initial begin
        reset_n = 1'b0; ir_in = '0; ltim = '0; imr = '0;
        ack_valid = 1'b0; ack_id = '0;
        tick(3);
        cmp("reset_irr", irr8, 8'h00);
        cmp("reset_pend", pend8_o, 1'b0);
        reset_n = 1'b1;
        tick(4);

        // Edge capture and ack on channel 3.
        ir_in[3] = 1'b1;
        tick(3);
        cmp("edge_irr", irr8, 8'h08);
        tick(1);
        cmp("edge_pend", pend8_o, 1'b1);
        cmp("edge_id", id8_o, 3'd3);
        ack_valid = 1'b1; ack_id = 3'd3;
        tick(1);
        ack_valid = 1'b0;
        cmp("ack_clr", irr8, 8'h00);
        tick(3);
        cmp("ack_hold_low", irr8, 8'h00);
        ir_in[3] = 1'b0;
        tick(3);

        // Level mode on channel 5, 4-cycle pulse.
        ltim = 8'hFF;
        tick(3);
        ir_in[5] = 1'b1;
        tick(3);
        cmp("lvl_set", irr8, 8'h20);
        ack_valid = 1'b1; ack_id = 3'd5;
        tick(1);
        ack_valid = 1'b0;
        cmp("lvl_ack_ignored", irr8, 8'h20);
        ir_in[5] = 1'b0;
        tick(2);
        cmp("lvl_tail", irr8, 8'h20);
        tick(1);
        cmp("lvl_drop", irr8, 8'h00);

        // Priority and mask.
        ltim = 8'h00;
        tick(3);
        imr = 8'h02; ir_in = 8'h52;
        tick(4);
        cmp("prio_irr", irr8, 8'h52);
        cmp("prio_id", id8_o, 3'd4);
        imr = 8'h52;
        tick(1);
        cmp("mask_pend", pend8_o, 1'b0);
        cmp("mask_id", id8_o, 3'd0);
        cmp("mask_irr", irr8, 8'h52);
        ir_in = 8'h00; imr = 8'h00;
        foreach (ir_in[i]) if (i == 1 || i == 4 || i == 6) begin
            ack_valid = 1'b1; ack_id = 3'(i);
            tick(1);
        end
        ack_valid = 1'b0;
        tick(3);

        // Simultaneous edge and ack on channel 2, then out-of-range ack.
        ir_in[2] = 1'b1;
        tick(4);
        ir_in[2] = 1'b0;
        tick(3);
        cmp("sim_pre", irr8, 8'h04);
        ir_in[2] = 1'b1;
        tick(2);
        ack_valid = 1'b1; ack_id = 3'd2;
        tick(1);
        ack_valid = 1'b0;
        cmp("set_wins", irr8, 8'h04);
        ack_valid = 1'b1; ack_id = 3'd7;
        tick(1);
        ack_id = 3'd6;
        tick(1);
        ack_valid = 1'b0;
        cmp("oor_irr6", irr6, 6'h04);
        ir_in = 8'h00;
        ack_valid = 1'b1; ack_id = 3'd2;
        tick(1);
        ack_valid = 1'b0;
        tick(3);

        // Reset mid-operation with channel 0 held high.
        ir_in = 8'h81;
        tick(3);
        cmp("pre_rst_irr", irr8, 8'h81);
        ir_in[7] = 1'b0;
        reset_n = 1'b0;
        tick(1);
        cmp("rst_irr", irr8, 8'h00);
        cmp("rst_pend", pend8_o, 1'b0);
        cmp("rst_id", id8_o, 3'd0);
        reset_n = 1'b1;
        tick(6);
        cmp("no_recapture", irr8, 8'h00);
        ir_in[0] = 1'b0;
        tick(2);
        ir_in[0] = 1'b1;
        tick(3);
        cmp("recapture", irr8, 8'h01);
        ir_in[0] = 1'b0;
        ack_valid = 1'b1; ack_id = 3'd0;
        tick(1);
        ack_valid = 1'b0;
        tick(3);

        // Level to edge switch on channel 1 with the line high.
        ltim = 8'h02; ir_in[1] = 1'b1;
        tick(4);
        cmp("sw_pre", irr8, 8'h02);
        ltim = 8'h00;
        tick(1);
        cmp("sw_clear", irr8, 8'h00);
        tick(4);
        cmp("sw_no_edge", irr8, 8'h00);
        ir_in[1] = 1'b0;
        tick(3);

        // Randomised traffic.
        for (int c = 0; c < 3000; c++) begin
            logic [7:0] fl;
            fl = 8'($urandom) & 8'($urandom) & 8'($urandom);
            ir_in = ir_in ^ fl;
            if ($urandom_range(0, 31) == 0) ltim[$urandom_range(0, 7)] = ~ltim[$urandom_range(0, 7)];
            if ($urandom_range(0, 15) == 0) imr = 8'($urandom) & 8'($urandom);
            ack_valid = ($urandom_range(0, 3) == 0);
            ack_id    = 3'($urandom);
            reset_n   = ($urandom_range(0, 499) != 0);
            tick(1);
        end
        reset_n = 1'b1;
        ack_valid = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/irr_multi_mode.md
# irr_multi_mode

Parametrised interrupt request register for the PIC. It captures NUM_IRQ asynchronous request lines through synchronisers and latches them per channel in edge- or level-triggered mode. It clears edge latches on acknowledge and presents a registered fixed-priority pending/ID pair to the in-service/priority logic downstream. It replaces the fixed 8-line, single-LTIM request register.

## Interface
- NUM_IRQ, default 8: number of request channels, 2..32.
- SYNC_STAGES, default 2: synchroniser depth on each ir_in line, 2..4.
- ID_W, default $clog2(NUM_IRQ): width of channel IDs (derived, not overridden).

- clk, input, 1: single clock; all state updates on the rising edge.
- reset_n, input, 1: synchronous, active-low reset.
- ir_in, input, NUM_IRQ: raw asynchronous request lines; bit i is channel i.
- ltim, input, NUM_IRQ: per-channel trigger mode; 1 = level, 0 = edge. Synchronous to clk.
- imr, input, NUM_IRQ: mask; 1 excludes the channel from priority resolution only. Masked channels still latch into irr.
- ack_valid, input, 1: acknowledge strobe, one cycle per acknowledge.
- ack_id, input, ID_W: channel acknowledged when ack_valid = 1.
- irr, output, NUM_IRQ: request register.
- irq_pending, output, 1: at least one unmasked irr bit was set in the previous cycle.
- highest_id, output, ID_W: lowest-index unmasked set irr bit from the previous cycle; 0 when irq_pending = 0.

## Operation
- Per channel, a chain of SYNC_STAGES flops produces s[i]. A further flop holds prev[i]. The rising-edge term is s[i] & ~prev[i].
- Edge mode (ltim[i] = 0):
  - irr[i] sets on a rising-edge term.
  - irr[i] clears on ack_valid with ack_id == i.
  - If an edge and an ack for the same channel occur in the same cycle, the set wins and irr[i] = 1.
  - Once set, irr[i] stays set after ir_in drops, until it is acknowledged.
- Level mode (ltim[i] = 1):
  - irr[i] <= s[i] every cycle.
  - ack has no effect on irr[i].
- Mode change: in any cycle where ltim[i] differs from its value in the previous cycle, the channel is reloaded:
  - irr[i] <= (new mode is level) ? s[i] : 0
  - prev[i] <= s[i]
  - A line that is already high therefore does not generate an edge after switching to edge mode.
- Acknowledge decoding:
  - An ack_id >= NUM_IRQ is ignored.
  - ack_valid is ignored for level-mode channels.
- Priority resolution:
  - Registered, from irr & ~imr.
  - Fixed priority: channel 0 is highest.
- Reset (reset_n = 0 at a clock edge):
  - Sync flops, prev, irr, irq_pending and highest_id all go to 0.
  - The ltim history register loads the current ltim value, so no mode-change event occurs on release.
  - A line held high through reset release produces no edge-mode request until it goes low and then high again. It does appear in irr after SYNC_STAGES cycles if the channel is in level mode.

## Timing
- Define edge 0 as the first clock edge at which ir_in[i] is sampled high.
- s[i] is high after edge SYNC_STAGES-1. irr[i] is high after edge SYNC_STAGES, in both modes.
- irq_pending and highest_id follow irr by exactly 1 cycle: high after edge SYNC_STAGES+1.
- Ack at edge k: irr[i] is 0 after edge k, and irq_pending/highest_id update after edge k+1.
- A pulse on ir_in shorter than one clock period may be missed. Edge-mode capture is guaranteed for a pulse high for at least 2 cycles, preceded by at least 2 cycles low.
- There are no combinational paths from inputs to outputs.

## Structure
- Package pic_pkg holds:
  - the NUM_IRQ and SYNC_STAGES default constants;
  - the ID_W derivation;
  - the mode encodings LTIM_EDGE = 0 and LTIM_LEVEL = 1, shared with the ICW1 decoder.
- Sub-module irr_channel, one per channel in a generate loop, contains:
  - the synchroniser chain;
  - prev, the ltim history bit and irr[i];
  - inputs clr (the decoded ack) and ltim[i].
- The top level contains the ack decoder and the registered priority encoder.

## Test plan
- Edge capture and ack:
  - Stimulus: NUM_IRQ = 8, ltim = 0x00; raise ir_in[3] at edge 0 and hold it.
  - Required: irr = 0x08 after edge 2; irq_pending = 1 and highest_id = 3 after edge 3.
  - Then pulse ack_valid with ack_id = 3; drop ir_in[3] later. Required: irr = 0x00 next cycle, and irr stays 0 while the line is held high.
- Level mode:
  - Stimulus: ltim = 0xFF; ir_in[5] high for 4 cycles, then low.
  - Required: irr[5] tracks the line delayed by 2 cycles.
  - Acking ID 5 while the line is high: irr[5] stays 1.
- Priority and mask:
  - Stimulus: irr sets bits 1, 4 and 6; imr = 0x02.
  - Required: highest_id = 4.
  - Then set imr = 0x52. Required: irq_pending = 0, highest_id = 0, irr unchanged at 0x52.
- Simultaneous set and clear:
  - Stimulus: an edge-mode channel 2 has irr[2] = 1; a new rising edge on channel 2 arrives in the same cycle as ack_id = 2.
  - Required: irr[2] = 1 afterwards.
  - Also ack_id = 7 with NUM_IRQ = 6: no irr change.
- Reset mid-operation:
  - Stimulus: irr = 0x81, ir_in[0] held high; assert reset_n = 0 for 1 cycle.
  - Required: irr, irq_pending and highest_id are 0 after that edge.
  - With ltim[0] = 0: no re-capture until the line toggles low then high.
- Mode switch:
  - Stimulus: channel 1 in level mode with the line high and irr[1] = 1; set ltim[1] = 0.
  - Required: irr[1] = 0 next cycle, and no request until a new rising edge.
